issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction FIFO depth in entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports instr_valid input 1, instr_ready output 1, instr_opcode input 8, instr_op1 input 32, instr_op2 input 32: the upstream instruction push interface.
REQ-005 SHALL have ports exe_enable output 1, exe_opcode output 8, exe_operand1 output 32, exe_operand2 output 32: drive the downstream execute stage.
REQ-006 SHALL have ports exe_result input 32, exe_overflow input 1, exe_done input 1: registered outputs returned by the execute stage.
REQ-007 SHALL have ports res_valid output 1, res_ready input 1, res_result output 32, res_overflow output 1, res_opcode output 8, res_err output 1: the result handshake interface.
REQ-008 SHALL have port fifo_count  output  clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-009 SHALL accept an instruction into the FIFO on any edge where instr_valid && instr_ready.
REQ-010 SHALL drive instr_ready = (fifo_count < DEPTH), combinationally from the count.
REQ-011 SHALL NOT bypass: an instruction pushed on edge E is poppable no earlier than edge E+1.
REQ-012 SHALL leave fifo_count unchanged on an edge with both push and pop; read/write pointers wrap modulo DEPTH.
REQ-013 SHALL implement states IDLE, ISSUE, CAPTURE, HOLD.
REQ-014 IDLE, fifo_count>0, head opcode <= 7: pop head into exe_opcode/exe_operand1/exe_operand2 registers; next state ISSUE.
REQ-015 IDLE, fifo_count>0, head opcode > 7: pop head; load res_opcode=head opcode, res_result=0, res_overflow=0, res_err=1; next state HOLD; exe_enable never asserted for it.
REQ-016 IDLE, fifo_count==0: remain IDLE.
REQ-017 exe_enable SHALL be 1 exactly for the one cycle spent in ISSUE, 0 in all other states; ISSUE always moves to CAPTURE.
REQ-018 exe_opcode/exe_operand1/exe_operand2 SHALL hold stable from the pop edge until the next pop.
REQ-019 CAPTURE: sample exe_result, exe_overflow into res_result, res_overflow, and set res_opcode=exe_opcode; next state HOLD (result is valid from execute only in this cycle, since execute clears it when not enabled).
REQ-020 CAPTURE: res_err=1 if (opcode in 1..7 and exe_done==0) or (opcode==0 and exe_done==1), else 0.
REQ-021 res_valid SHALL be 1 iff state is HOLD; res_* SHALL hold stable while res_valid && !res_ready.
REQ-022 HOLD with res_ready=1: next state IDLE; res_valid drops on that edge.
REQ-023 Latency: a push on edge E0 into an empty FIFO with idle FSM gives exe_enable high between E1 and E2, and res_valid high after E3; minimum spacing between results is 4 cycles.
REQ-024 A push SHALL proceed in any FSM state, including HOLD backpressure, while fifo_count < DEPTH.

Reset
REQ-025 On reset assertion, asynchronously: state=IDLE, FIFO pointers and fifo_count=0, exe_enable=0, exe_opcode=0, exe_operand1=0, exe_operand2=0, res_valid=0, res_result=0, res_overflow=0, res_opcode=0, res_err=0; instr_ready=1 follows from count.
REQ-026 Reset mid-operation (any state) SHALL discard FIFO contents and any in-flight or held result without emitting it.
REQ-027 After reset deassertion, the first push SHALL be accepted on the first rising edge with instr_valid=1.

Verification
REQ-028 Push opcode 1, op1=32'hFFFF_FFFF, op2=1, res_ready=1 -> exe_enable one cycle; res_valid 3 edges after push; res_result=0, res_overflow=1, res_err=0, res_opcode=1.
REQ-029 Push opcode 9, op1=5, op2=6 -> exe_enable stays 0; res_valid with res_result=0, res_overflow=0, res_err=1, res_opcode=9.
REQ-030 res_ready=0, push 5 instructions back-to-back -> fifo_count reaches 4 and instr_ready=0 (4 queued; first popped into issue and held in HOLD); 5th accepted only after a pop; with res_ready=1, results emerge in push order, each 4 cycles apart.
REQ-031 Push opcode 0 -> res_result=0, res_err=0 when exe_done returns 0; force exe_done=1 -> res_err=1.
REQ-032 Assert reset during ISSUE with 2 entries queued -> fifo_count=0, exe_enable=0, res_valid=0 immediately; no result emitted after release.
REQ-033 Push opcode 3, op1=32'h0001_0000, op2=32'h0001_0000 -> res_result=0, res_overflow=1; push opcode 2, op1=3, op2=5 -> res_result=32'hFFFF_FFFE, res_overflow=1.

Source files
------------

// File: rtl/issue_ctrl.sv
// Instruction issue controller: buffers pushed instructions in a FIFO, issues them
// one at a time to an execute stage and presents each result through a valid/ready port.
module issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [7:0]                 instr_opcode,
    input  logic [31:0]                instr_op1,
    input  logic [31:0]                instr_op2,
    output logic                       exe_enable,
    output logic [7:0]                 exe_opcode,
    output logic [31:0]                exe_operand1,
    output logic [31:0]                exe_operand2,
    input  logic [31:0]                exe_result,
    input  logic                       exe_overflow,
    input  logic                       exe_done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [31:0]                res_result,
    output logic                       res_overflow,
    output logic [7:0]                 res_opcode,
    output logic                       res_err,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its payload stable until that edge.

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    exe_opcode_q, exe_opcode_d;
    logic [31:0]   exe_op1_q, exe_op1_d;
    logic [31:0]   exe_op2_q, exe_op2_d;
    logic [31:0]   res_result_q, res_result_d;
    logic          res_overflow_q, res_overflow_d;
    logic [7:0]    res_opcode_q, res_opcode_d;
    logic          res_err_q, res_err_d;

    logic [7:0]    mem_opcode_q [DEPTH];
    logic [31:0]   mem_op1_q    [DEPTH];
    logic [31:0]   mem_op2_q    [DEPTH];

    logic          push;
    logic          pop;
    logic [7:0]    head_opcode;

    assign instr_ready = (count_q < CW'(DEPTH));
    assign push        = instr_valid && instr_ready;
    assign pop         = (state_q == IDLE) && (count_q != '0);
    assign head_opcode = mem_opcode_q[rd_ptr_q];

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_opcode_q[wr_ptr_q] <= instr_opcode;
            mem_op1_q[wr_ptr_q]    <= instr_op1;
            mem_op2_q[wr_ptr_q]    <= instr_op2;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        exe_opcode_d   = exe_opcode_q;
        exe_op1_d      = exe_op1_q;
        exe_op2_d      = exe_op2_q;
        res_result_d   = res_result_q;
        res_overflow_d = res_overflow_q;
        res_opcode_d   = res_opcode_q;
        res_err_d      = res_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (head_opcode <= 8'd7) begin
                        exe_opcode_d = head_opcode;
                        exe_op1_d    = mem_op1_q[rd_ptr_q];
                        exe_op2_d    = mem_op2_q[rd_ptr_q];
                        state_d      = ISSUE;
                    end else begin
                        // Unknown opcode: report an error result without using the execute stage.
                        res_opcode_d   = head_opcode;
                        res_result_d   = '0;
                        res_overflow_d = 1'b0;
                        res_err_d      = 1'b1;
                        state_d        = HOLD;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Execute output is only meaningful in the cycle right after enable.
                res_result_d   = exe_result;
                res_overflow_d = exe_overflow;
                res_opcode_d   = exe_opcode_q;
                res_err_d      = ((exe_opcode_q != 8'd0) && !exe_done) ||
                                 ((exe_opcode_q == 8'd0) && exe_done);
                state_d        = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            exe_opcode_q   <= '0;
            exe_op1_q      <= '0;
            exe_op2_q      <= '0;
            res_result_q   <= '0;
            res_overflow_q <= 1'b0;
            res_opcode_q   <= '0;
            res_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            exe_opcode_q   <= exe_opcode_d;
            exe_op1_q      <= exe_op1_d;
            exe_op2_q      <= exe_op2_d;
            res_result_q   <= res_result_d;
            res_overflow_q <= res_overflow_d;
            res_opcode_q   <= res_opcode_d;
            res_err_q      <= res_err_d;
        end
    end

    assign exe_enable   = (state_q == ISSUE);
    assign exe_opcode   = exe_opcode_q;
    assign exe_operand1 = exe_op1_q;
    assign exe_operand2 = exe_op2_q;
    assign res_valid    = (state_q == HOLD);
    assign res_result   = res_result_q;
    assign res_overflow = res_overflow_q;
    assign res_opcode   = res_opcode_q;
    assign res_err      = res_err_q;
    assign fifo_count   = count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a small registered execute-stage model.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  instr_opcode = '0;
    logic [31:0] instr_op1 = '0;
    logic [31:0] instr_op2 = '0;
    logic        exe_enable;
    logic [7:0]  exe_opcode;
    logic [31:0] exe_operand1;
    logic [31:0] exe_operand2;
    logic [31:0] exe_result;
    logic        exe_overflow;
    logic        exe_done;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_result;
    logic        res_overflow;
    logic [7:0]  res_opcode;
    logic        res_err;
    logic [2:0]  fifo_count;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int rv_cnt = 0;
    logic force_done = 1'b0;
    logic drop_done = 1'b0;
    logic [39:0] exp_q[$];

    issue_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_op1(instr_op1), .instr_op2(instr_op2),
        .exe_enable(exe_enable), .exe_opcode(exe_opcode),
        .exe_operand1(exe_operand1), .exe_operand2(exe_operand2),
        .exe_result(exe_result), .exe_overflow(exe_overflow), .exe_done(exe_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_result(res_result),
        .res_overflow(res_overflow), .res_opcode(res_opcode), .res_err(res_err),
        .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Execute stage: registered, clears its outputs whenever it is not enabled.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_result <= '0; exe_overflow <= 1'b0; exe_done <= 1'b0;
        end else if (exe_enable) begin
            logic [63:0] p;
            logic [32:0] s;
            p = 64'(exe_operand1) * 64'(exe_operand2);
            exe_done <= drop_done ? 1'b0 : 1'b1;
            exe_overflow <= 1'b0;
            case (exe_opcode)
                8'd1: begin s = {1'b0, exe_operand1} + {1'b0, exe_operand2};
                            exe_result <= s[31:0]; exe_overflow <= s[32]; end
                8'd2: begin exe_result <= exe_operand1 - exe_operand2;
                            exe_overflow <= (exe_operand1 < exe_operand2); end
                8'd3: begin exe_result <= p[31:0]; exe_overflow <= |p[63:32]; end
                8'd4: exe_result <= exe_operand1 & exe_operand2;
                8'd5: exe_result <= exe_operand1 | exe_operand2;
                8'd6: exe_result <= exe_operand1 ^ exe_operand2;
                8'd7: exe_result <= exe_operand1;
                default: begin exe_result <= '0; exe_done <= force_done; end
            endcase
        end else begin
            exe_result <= '0; exe_overflow <= 1'b0; exe_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (exe_enable) en_cnt <= en_cnt + 1;
        if (res_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
        instr_valid = 1'b1; instr_opcode = opc; instr_op1 = a; instr_op2 = b;
        tick();
        instr_valid = 1'b0;
    endtask

    // Push one instruction into an idle, empty controller and check the returned result.
    task automatic run_one(input string tag, input logic [7:0] opc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic eo,
                           input logic ee);
        int n;
        int en_base;
        int exp_lat;
        exp_lat = (opc <= 8'd7) ? 3 : 1;
        en_base = en_cnt;
        push(opc, a, b);
        n = 0;
        while (!res_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, ".valid"}, 40'(res_valid), 40'(1));
        check({tag, ".lat"}, 40'(n), 40'(exp_lat));
        check({tag, ".result"}, 40'(res_result), 40'(er));
        check({tag, ".ovf"}, 40'(res_overflow), 40'(eo));
        check({tag, ".err"}, 40'(res_err), 40'(ee));
        check({tag, ".opcode"}, 40'(res_opcode), 40'(opc));
        check({tag, ".en_pulses"}, 40'(en_cnt - en_base), 40'((opc <= 8'd7) ? 1 : 0));
        tick();
        check({tag, ".valid_drop"}, 40'(res_valid), 40'(0));
    endtask

    initial begin
        int n;
        int last;
        int base_rv;
        int base_en;
        logic [7:0]  opcs [5];
        logic [31:0] as   [5];
        logic [31:0] bs   [5];
        logic [31:0] rs   [5];
        logic [39:0] e;

        opcs = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd1};
        as   = '{32'h0000_F0F0, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_1234, 32'h10};
        bs   = '{32'h0000_FF00, 32'h0000_000F, 32'h0000_000F, 32'h0000_0000, 32'h20};
        rs   = '{32'h0000_F000, 32'h0000_00FF, 32'h0000_00F0, 32'h0000_1234, 32'h30};

        repeat (2) tick();
        check("rst.count", 40'(fifo_count), 40'(0));
        check("rst.ready", 40'(instr_ready), 40'(1));
        check("rst.enable", 40'(exe_enable), 40'(0));
        check("rst.valid", 40'(res_valid), 40'(0));
        check("rst.result", 40'({res_opcode, res_result}), 40'(0));
        check("rst.flags", 40'({res_overflow, res_err}), 40'(0));
        check("rst.exe", 40'({exe_opcode, exe_operand1 | exe_operand2}), 40'(0));
        check("rst.state", 40'(dbg_state), 40'(0));
        reset = 1'b0;

        run_one("add_ovf", 8'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        check("add_ovf.exe_hold", 40'({exe_opcode, exe_operand1}), {8'd1, 32'hFFFF_FFFF});
        run_one("bad_op9", 8'd9, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
        run_one("bad_op8", 8'd8, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        run_one("nop", 8'd0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0);
        force_done = 1'b1;
        run_one("nop_done", 8'd0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1);
        force_done = 1'b0;
        run_one("mul_ovf", 8'd3, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0);
        run_one("sub_brw", 8'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_one("op7", 8'd7, 32'h0000_DEAD, 32'd0, 32'h0000_DEAD, 1'b0, 1'b0);
        drop_done = 1'b1;
        run_one("no_done", 8'd1, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
        drop_done = 1'b0;

        // Backpressure: fill the FIFO while the first result is held.
        res_ready = 1'b0;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_opcode = opcs[i]; instr_op1 = as[i]; instr_op2 = bs[i];
            exp_q.push_back({opcs[i], rs[i]});
            tick();
        end
        check("full.count", 40'(fifo_count), 40'(4));
        check("full.ready", 40'(instr_ready), 40'(0));
        check("full.valid", 40'(res_valid), 40'(1));
        instr_opcode = 8'd5; instr_op1 = 32'hAAAA; instr_op2 = 32'h5555;
        repeat (3) tick();
        check("full.blocked", 40'(fifo_count), 40'(4));
        check("full.held", 40'({res_opcode, res_result}), {8'd4, 32'h0000_F000});
        instr_valid = 1'b0;
        res_ready = 1'b1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!res_valid && n < 20) begin
                tick();
                n++;
            end
            check("drain.valid", 40'(res_valid), 40'(1));
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
            check("drain.data", {res_opcode, res_result}, e);
            if (k > 0) check("drain.spacing", 40'(cyc - last), 40'(4));
            if (k == 1) check("drain.ready", 40'(instr_ready), 40'(1));
            last = cyc;
            tick();
        end
        base_rv = rv_cnt;
        repeat (6) tick();
        check("drain.empty", 40'(fifo_count), 40'(0));
        check("drain.no_extra", 40'(rv_cnt - base_rv), 40'(0));

        // Reset while ISSUE is active with two entries still queued.
        res_ready = 1'b0;
        push(8'd1, 32'd1, 32'd1);
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_opcode = 8'd4; instr_op1 = 32'(i); instr_op2 = 32'hFF;
            tick();
        end
        instr_valid = 1'b0;
        tick();
        check("rst_mid.hold", 40'(res_valid), 40'(1));
        check("rst_mid.count3", 40'(fifo_count), 40'(3));
        res_ready = 1'b1;
        repeat (2) tick();
        check("rst_mid.issue", 40'(exe_enable), 40'(1));
        check("rst_mid.count2", 40'(fifo_count), 40'(2));
        base_rv = rv_cnt;
        base_en = en_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_mid.count0", 40'(fifo_count), 40'(0));
        check("rst_mid.enable0", 40'(exe_enable), 40'(0));
        check("rst_mid.valid0", 40'(res_valid), 40'(0));
        check("rst_mid.ready1", 40'(instr_ready), 40'(1));
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();
        check("rst_mid.no_result", 40'(rv_cnt - base_rv), 40'(0));
        check("rst_mid.no_issue", 40'(en_cnt - base_en), 40'(0));

        run_one("post_rst", 8'd1, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
